// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C types and constants
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_TX_BYTE,
    ST_RX_ACK,
    ST_WAIT_STOP
  } i2c_stx_state_t;

  localparam logic I2C_RW_READ = 1'b1;
  localparam int   SYNC_STAGES = 2;

endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronizer with edge, START and STOP detection
module i2c_bus_sync
  import i2c_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  logic scl_rise_q, scl_rise_d, scl_fall_q, scl_fall_d;
  logic start_q, start_d, stop_q, stop_d;
  logic scl_s, sda_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Pulses are registered so the SDA level presented with them is the same-age sample.
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], i_scl};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], i_sda};
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
    scl_rise_d = scl_s & ~scl_prev_q;
    scl_fall_d = ~scl_s & scl_prev_q;
    start_d    = scl_s & scl_prev_q & ~sda_s & sda_prev_q;
    stop_d     = scl_s & scl_prev_q & sda_s & ~sda_prev_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      scl_sync_q <= {SYNC_STAGES{1'b1}};
      sda_sync_q <= {SYNC_STAGES{1'b1}};
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
      scl_rise_q <= scl_rise_d;
      scl_fall_q <= scl_fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  assign o_sda      = sda_prev_q;
  assign o_scl_rise = scl_rise_q;
  assign o_scl_fall = scl_fall_q;
  assign o_start    = start_q;
  assign o_stop     = stop_q;

endmodule

// File: rtl/i2c_slave_tx.sv
// rtl/i2c_slave_tx.sv - I2C slave transmitter; clock stretching when I2C_SLAVE_TX_CLK_STRETCH_EN is defined
module i2c_slave_tx
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR = 7'h50
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_scl_oe,
  output logic       o_sda_oe,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_busy,
  output logic       o_addr_hit,
  output logic       o_byte_done,
  output logic       o_nack,
  output logic       o_underrun
);

  logic sync_rst_n, sda_s, scl_rise, scl_fall, start_det, stop_det;
  i2c_stx_state_t state_q, state_d;
  logic [7:0] sr_q, sr_d, hold_q, hold_d, tx_byte;
  logic [2:0] cnt_q, cnt_d;
  logic sda_oe_q, sda_oe_d, hold_full_q, hold_full_d;
  logic addr_hit_q, addr_hit_d, byte_done_q, byte_done_d;
  logic nack_q, nack_d, underrun_q, underrun_d;
  logic load_pt, consume;
`ifdef I2C_SLAVE_TX_CLK_STRETCH_EN
  logic scl_oe_q, scl_oe_d, stall_q, stall_d;
  logic [1:0] str_cnt_q, str_cnt_d;
`endif

  assign sync_rst_n = i_rst_n & i_en;

  i2c_bus_sync u_sync (
    .i_clk      (i_clk),
    .i_rst_n    (sync_rst_n),
    .i_scl      (i_scl),
    .i_sda      (i_sda),
    .o_sda      (sda_s),
    .o_scl_rise (scl_rise),
    .o_scl_fall (scl_fall),
    .o_start    (start_det),
    .o_stop     (stop_det)
  );

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    sda_oe_d    = sda_oe_q;
    addr_hit_d  = 1'b0;
    byte_done_d = 1'b0;
    nack_d      = nack_q;
    underrun_d  = underrun_q;
    consume     = 1'b0;
    tx_byte     = hold_full_q ? hold_q : i_tx_data;
    // cnt_q==0 in the ACK states means the bit that precedes a data byte is done.
    load_pt     = (state_q == ST_ADDR_ACK || state_q == ST_RX_ACK) && cnt_q == 3'd0 && scl_fall;
`ifdef I2C_SLAVE_TX_CLK_STRETCH_EN
    scl_oe_d  = scl_oe_q;
    stall_d   = stall_q;
    str_cnt_d = str_cnt_q;
    if (str_cnt_q != 2'd0) begin
      str_cnt_d = str_cnt_q - 2'd1;
      if (str_cnt_q == 2'd1) scl_oe_d = 1'b0;
    end
    if (stall_q) load_pt = 1'b1;
`endif

    case (state_q)
      ST_ADDR: if (scl_rise) begin
        sr_d  = {sr_q[6:0], sda_s};
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd0) begin
          if (sr_q[6:0] == ADDR && sda_s == I2C_RW_READ) begin
            state_d    = ST_ADDR_ACK;
            addr_hit_d = 1'b1;
            cnt_d      = 3'd1;
          end else begin
            state_d = ST_WAIT_STOP;
          end
        end
      end
      ST_ADDR_ACK: if (scl_fall && cnt_q == 3'd1) begin
        sda_oe_d = 1'b1;
        cnt_d    = 3'd0;
      end
      ST_TX_BYTE: if (scl_fall) begin
        if (cnt_q == 3'd0) begin
          sda_oe_d = 1'b0;
          state_d  = ST_RX_ACK;
          cnt_d    = 3'd1;
        end else begin
          sr_d     = {sr_q[6:0], 1'b0};
          sda_oe_d = ~sr_q[6];
          cnt_d    = cnt_q - 3'd1;
        end
      end
      ST_RX_ACK: if (scl_rise && cnt_q == 3'd1) begin
        byte_done_d = 1'b1;
        if (sda_s) begin
          nack_d  = 1'b1;
          state_d = ST_WAIT_STOP;
        end else begin
          cnt_d = 3'd0;
        end
      end
      default: sda_oe_d = 1'b0;
    endcase

    if (load_pt) begin
      if (hold_full_q || i_tx_valid) begin
        consume  = 1'b1;
        sr_d     = tx_byte;
        sda_oe_d = ~tx_byte[7];
        cnt_d    = 3'd7;
        state_d  = ST_TX_BYTE;
`ifdef I2C_SLAVE_TX_CLK_STRETCH_EN
        stall_d = 1'b0;
        if (stall_q) str_cnt_d = 2'd2;
`endif
      end else begin
`ifdef I2C_SLAVE_TX_CLK_STRETCH_EN
        stall_d  = 1'b1;
        scl_oe_d = 1'b1;
`else
        sr_d       = 8'hFF;
        sda_oe_d   = 1'b0;
        cnt_d      = 3'd7;
        state_d    = ST_TX_BYTE;
        underrun_d = 1'b1;
`endif
      end
    end

    if (start_det || stop_det) begin
      state_d    = start_det ? ST_ADDR : ST_IDLE;
      cnt_d      = 3'd7;
      sda_oe_d   = 1'b0;
      consume    = 1'b0;
      addr_hit_d = 1'b0;
      if (start_det) begin
        nack_d     = 1'b0;
        underrun_d = 1'b0;
      end
`ifdef I2C_SLAVE_TX_CLK_STRETCH_EN
      scl_oe_d  = 1'b0;
      stall_d   = 1'b0;
      str_cnt_d = 2'd0;
`endif
    end

    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (consume && i_en) begin
      hold_full_d = 1'b0;
    end else if (i_tx_valid && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_d      = i_tx_data;
    end
  end

  // The holding register survives i_en=0; only a real reset empties it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!sync_rst_n) begin
      state_q     <= ST_IDLE;
      sr_q        <= 8'h00;
      cnt_q       <= 3'd7;
      sda_oe_q    <= 1'b0;
      addr_hit_q  <= 1'b0;
      byte_done_q <= 1'b0;
      nack_q      <= 1'b0;
      underrun_q  <= 1'b0;
`ifdef I2C_SLAVE_TX_CLK_STRETCH_EN
      scl_oe_q    <= 1'b0;
      stall_q     <= 1'b0;
      str_cnt_q   <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      sda_oe_q    <= sda_oe_d;
      addr_hit_q  <= addr_hit_d;
      byte_done_q <= byte_done_d;
      nack_q      <= nack_d;
      underrun_q  <= underrun_d;
`ifdef I2C_SLAVE_TX_CLK_STRETCH_EN
      scl_oe_q    <= scl_oe_d;
      stall_q     <= stall_d;
      str_cnt_q   <= str_cnt_d;
`endif
    end
  end

  assign o_sda_oe = sda_oe_q & sync_rst_n;
`ifdef I2C_SLAVE_TX_CLK_STRETCH_EN
  assign o_scl_oe = scl_oe_q & sync_rst_n;
`else
  assign o_scl_oe = 1'b0;
`endif
  assign o_tx_ready  = ~hold_full_q;
  assign o_busy      = (state_q == ST_ADDR_ACK) || (state_q == ST_TX_BYTE) || (state_q == ST_RX_ACK);
  assign o_addr_hit  = addr_hit_q;
  assign o_byte_done = byte_done_q;
  assign o_nack      = nack_q;
  assign o_underrun  = underrun_q;

endmodule

// File: tb/tb_i2c_slave_tx.sv
// tb/tb_i2c_slave_tx.sv - randomized bench for i2c_slave_tx against a bus-level master model
module tb_i2c_slave_tx;
  import i2c_pkg::*;

  localparam int Q = 10;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, m_scl = 1'b1, m_sda = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0;
  logic scl_oe, sda_oe, tx_ready, busy, addr_hit, byte_done, nack, underrun;
  logic scl_bus, sda_bus;
  int total = 0, bad = 0;
  int hit_cnt = 0, done_cnt = 0, rdy_rise = 0, busy_cyc = 0, sdaoe_cyc = 0;
  logic rdy_prev = 1'b1;
  logic [7:0] feed_q[$];
  logic [7:0] rx_q[$];

  assign scl_bus = m_scl & ~scl_oe;
  assign sda_bus = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_tx dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_scl(scl_bus), .i_sda(sda_bus),
    .o_scl_oe(scl_oe), .o_sda_oe(sda_oe), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
    .o_tx_ready(tx_ready), .o_busy(busy), .o_addr_hit(addr_hit), .o_byte_done(byte_done),
    .o_nack(nack), .o_underrun(underrun)
  );

  always @(negedge clk) begin
    if (addr_hit) hit_cnt++;
    if (byte_done) done_cnt++;
    if (busy) busy_cyc++;
    if (sda_oe) sdaoe_cyc++;
    if (tx_ready && !rdy_prev) rdy_rise++;
    rdy_prev = tx_ready;
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic scl_high();
    int n = 0;
    m_scl = 1'b1;
    while (scl_bus !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin total++; bad++; $display("FAIL scl_release: scl=%b after %0d cycles, need 1", scl_bus, n); end
  endtask

  task automatic m_start();
    m_sda = 1'b1; wait_q(); scl_high(); wait_q(); m_sda = 1'b0; wait_q(); m_scl = 1'b0; wait_q();
  endtask

  task automatic m_stop();
    m_sda = 1'b0; wait_q(); scl_high(); wait_q(); m_sda = 1'b1; wait_q();
  endtask

  task automatic m_write_bit(input logic b);
    m_sda = b; wait_q(); scl_high(); wait_q(); wait_q(); m_scl = 1'b0; wait_q();
  endtask

  task automatic m_read_bit(output logic b);
    m_sda = 1'b1; wait_q(); scl_high(); wait_q(); b = sda_bus; wait_q(); m_scl = 1'b0; wait_q();
  endtask

  task automatic m_addr_bits(input logic [6:0] a, input logic rw, output logic ack);
    logic [7:0] ab;
    logic b;
    ab = {a, rw};
    for (int i = 7; i >= 0; i--) m_write_bit(ab[i]);
    m_read_bit(b);
    ack = ~b;
  endtask

  task automatic m_read_byte(input logic last, output logic [7:0] d);
    logic b;
    d = 8'h00;
    for (int i = 7; i >= 0; i--) begin m_read_bit(b); d[i] = b; end
    m_write_bit(last);
  endtask

  task automatic feeder(input int n);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      while (tx_ready !== 1'b1 && w < 5000) begin @(negedge clk); w++; end
      if (w >= 5000) begin total++; bad++; $display("FAIL feed_wait: tx_ready=%b, need 1 for byte %0d", tx_ready, i); end
      tx_data = feed_q[i]; tx_valid = 1'b1; @(negedge clk); tx_valid = 1'b0;
    end
  endtask

  // Master read of n bytes: ACK all but the last, NACK the last, then STOP.
  task automatic run_read(input logic [6:0] a, input logic rw, input int n, input bit do_feed, output logic ack);
    logic ack_l;
    ack_l = 1'b0;
    rx_q.delete();
    fork
      if (do_feed) feeder(n);
      begin
        m_start();
        m_addr_bits(a, rw, ack_l);
        if (ack_l) for (int i = 0; i < n; i++) begin
          logic [7:0] d;
          m_read_byte(i == n - 1, d);
          rx_q.push_back(d);
        end
        m_stop();
      end
    join
    ack = ack_l;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if ({scl_oe, sda_oe, tx_ready, busy, addr_hit, byte_done, nack, underrun} !== 8'b0010_0000) begin
      bad++; $display("FAIL reset_outputs: got %b need 00100000", {scl_oe, sda_oe, tx_ready, busy, addr_hit, byte_done, nack, underrun});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single_read();
    int h0, d0;
    logic ack;
    h0 = hit_cnt; d0 = done_cnt;
    feed_q = '{8'hA5};
    run_read(7'h50, 1'b1, 1, 1'b1, ack);
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL single_ack: got %b need 1", ack); end
    total++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin bad++; $display("FAIL single_data: got %h need a5", rx_q.size() ? rx_q[0] : 8'hxx); end
    total++; if (hit_cnt - h0 != 1) begin bad++; $display("FAIL single_hits: got %0d need 1", hit_cnt - h0); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL single_done: got %0d need 1", done_cnt - d0); end
    total++; if (nack !== 1'b1) begin bad++; $display("FAIL single_nack: got %b need 1", nack); end
    total++; if (dut.state_q !== ST_IDLE || busy !== 1'b0) begin bad++; $display("FAIL single_idle: state %0d busy %b need idle/0", dut.state_q, busy); end
  endtask

  task automatic test_addr_mismatch();
    int h0, s0;
    logic ack, b;
    logic [7:0] bits;
    h0 = hit_cnt; s0 = sdaoe_cyc;
    m_start();
    m_addr_bits(7'h51, 1'b1, ack);
    for (int i = 7; i >= 0; i--) begin m_read_bit(b); bits[i] = b; end
    total++; if (dut.state_q !== ST_WAIT_STOP) begin bad++; $display("FAIL mismatch_wait: state %0d need WAIT_STOP", dut.state_q); end
    m_stop();
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL mismatch_ack: got %b need 0", ack); end
    total++; if (bits !== 8'hFF) begin bad++; $display("FAIL mismatch_sda: got %h need ff", bits); end
    total++; if (hit_cnt != h0 || sdaoe_cyc != s0) begin bad++; $display("FAIL mismatch_quiet: hits %0d oe_cycles %0d need 0 0", hit_cnt - h0, sdaoe_cyc - s0); end
    total++; if (dut.state_q !== ST_IDLE) begin bad++; $display("FAIL mismatch_idle: state %0d need IDLE", dut.state_q); end
  endtask

  task automatic test_write();
    int b0;
    logic ack;
    b0 = busy_cyc;
    m_start();
    m_addr_bits(7'h50, 1'b0, ack);
    m_stop();
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL write_ack: got %b need 0", ack); end
    total++; if (busy_cyc != b0) begin bad++; $display("FAIL write_busy: busy cycles %0d need 0", busy_cyc - b0); end
  endtask

  task automatic test_multi_read();
    int r0, d0;
    logic ack;
    logic [7:0] exp_b[3];
    exp_b = '{8'h11, 8'h22, 8'h33};
    r0 = rdy_rise; d0 = done_cnt;
    feed_q = '{8'h11, 8'h22, 8'h33};
    run_read(7'h50, 1'b1, 3, 1'b1, ack);
    total++; if (ack !== 1'b1 || rx_q.size() != 3) begin bad++; $display("FAIL multi_len: ack %b bytes %0d need 1 3", ack, rx_q.size()); end
    for (int i = 0; i < 3; i++) begin
      total++; if (rx_q[i] !== exp_b[i]) begin bad++; $display("FAIL multi_byte%0d: got %h need %h", i, rx_q[i], exp_b[i]); end
    end
    total++; if (rdy_rise - r0 != 3) begin bad++; $display("FAIL multi_ready: rises %0d need 3", rdy_rise - r0); end
    total++; if (done_cnt - d0 != 3) begin bad++; $display("FAIL multi_done: got %0d need 3", done_cnt - d0); end
  endtask

  task automatic test_empty_holding();
    logic ack;
`ifdef I2C_SLAVE_TX_CLK_STRETCH_EN
    logic [7:0] d;
    ack = 1'b0; d = 8'h00;
    fork
      begin
        m_start(); m_addr_bits(7'h50, 1'b1, ack); m_read_byte(1'b1, d); m_stop();
      end
      begin
        int w = 0;
        while (scl_oe !== 1'b1 && w < 4000) begin @(negedge clk); w++; end
        total++; if (w >= 4000) begin bad++; $display("FAIL stretch_start: scl_oe=%b need 1", scl_oe); end
        repeat (60) @(negedge clk);
        total++; if (scl_bus !== 1'b0) begin bad++; $display("FAIL stretch_hold: scl=%b need 0", scl_bus); end
        tx_data = 8'h3C; tx_valid = 1'b1; @(negedge clk); tx_valid = 1'b0;
      end
    join
    total++; if (ack !== 1'b1 || d !== 8'h3C) begin bad++; $display("FAIL stretch_data: ack %b byte %h need 1 3c", ack, d); end
    total++; if (underrun !== 1'b0 || scl_oe !== 1'b0) begin bad++; $display("FAIL stretch_flags: underrun %b scl_oe %b need 0 0", underrun, scl_oe); end
`else
    run_read(7'h50, 1'b1, 1, 1'b0, ack);
    total++; if (ack !== 1'b1 || rx_q.size() != 1 || rx_q[0] !== 8'hFF) begin bad++; $display("FAIL underrun_data: ack %b byte %h need 1 ff", ack, rx_q.size() ? rx_q[0] : 8'hxx); end
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_flag: got %b need 1", underrun); end
`endif
  endtask

  task automatic test_rstart_reset();
    int h0;
    logic ack, b;
    logic [7:0] d, r;
    h0 = hit_cnt;
    feed_q = '{8'hF0};
    feeder(1);
    m_start(); m_addr_bits(7'h50, 1'b1, ack);
    for (int i = 0; i < 3; i++) m_read_bit(b);
    r = 8'($urandom_range(0, 255));
    feed_q = '{r};
    feeder(1);
    m_start();
    total++; if (dut.state_q !== ST_ADDR || sda_oe !== 1'b0) begin bad++; $display("FAIL rstart_addr: state %0d sda_oe %b need ADDR 0", dut.state_q, sda_oe); end
    m_addr_bits(7'h50, 1'b1, ack); m_read_byte(1'b1, d); m_stop();
    total++; if (ack !== 1'b1 || d !== r) begin bad++; $display("FAIL rstart_data: ack %b byte %h need 1 %h", ack, d, r); end
    total++; if (hit_cnt - h0 != 2) begin bad++; $display("FAIL rstart_hits: got %0d need 2", hit_cnt - h0); end

    feed_q = '{8'h00};
    feeder(1);
    m_start(); m_addr_bits(7'h50, 1'b1, ack);
    for (int i = 0; i < 3; i++) m_read_bit(b);
    @(negedge clk);
    total++; if (sda_oe !== 1'b1) begin bad++; $display("FAIL rst_pre_drive: sda_oe %b need 1", sda_oe); end
    rst_n = 1'b0;
    #1;
    total++; if (sda_oe !== 1'b0 || scl_oe !== 1'b0) begin bad++; $display("FAIL rst_same_cycle: sda_oe %b scl_oe %b need 0 0", sda_oe, scl_oe); end
    @(posedge clk); #1;
    total++;
    if ({scl_oe, sda_oe, tx_ready, busy, addr_hit, byte_done, nack, underrun} !== 8'b0010_0000 || dut.state_q !== ST_IDLE) begin
      bad++; $display("FAIL rst_outputs: got %b state %0d need 00100000 IDLE", {scl_oe, sda_oe, tx_ready, busy, addr_hit, byte_done, nack, underrun}, dut.state_q);
    end
    m_sda = 1'b1; repeat (5) @(negedge clk); m_scl = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      logic [6:0] a;
      logic rw, ack, exp_ack;
      int n, h0, d0;
      a  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'h50;
      rw = ($urandom_range(0, 4) != 0);
      n  = $urandom_range(1, 3);
      exp_ack = (a == 7'h50) && rw;
      feed_q.delete();
      for (int i = 0; i < n; i++) feed_q.push_back(8'($urandom_range(0, 255)));
      h0 = hit_cnt; d0 = done_cnt;
      run_read(a, rw, n, exp_ack, ack);
      total++; if (ack !== exp_ack) begin bad++; $display("FAIL rand%0d_ack: addr %h rw %b got %b need %b", it, a, rw, ack, exp_ack); end
      total++; if (hit_cnt - h0 != (exp_ack ? 1 : 0)) begin bad++; $display("FAIL rand%0d_hits: got %0d need %0d", it, hit_cnt - h0, exp_ack ? 1 : 0); end
      if (exp_ack) begin
        for (int i = 0; i < n; i++) begin
          total++; if (rx_q[i] !== feed_q[i]) begin bad++; $display("FAIL rand%0d_byte%0d: got %h need %h", it, i, rx_q[i], feed_q[i]); end
        end
        total++; if (done_cnt - d0 != n || nack !== 1'b1 || underrun !== 1'b0) begin
          bad++; $display("FAIL rand%0d_flags: done %0d nack %b underrun %b need %0d 1 0", it, done_cnt - d0, nack, underrun, n);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_addr_mismatch();
    test_write();
    test_multi_read();
    test_empty_holding();
    test_rstart_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_slave_tx.md
# i2c_slave_tx

I2C slave-transmitter peripheral that answers master read transactions on an open-drain bus. It detects START/STOP, matches a 7-bit slave address with R/W=1, ACKs it, and shifts out bytes supplied by the SoC through a one-entry valid/ready holding register. It honours the master's ACK/NACK after each byte. It is the bus-side counterpart of the I2C master receiver and sits behind the same APB-style peripheral wrapper.

## Interface
- ADDR, 7'h50, slave address matched against the first 7 bits after START.
- i_clk  in  1  system clock; must be at least 16× the SCL frequency.
- i_rst_n  in  1  synchronous, active-low reset.
- i_en  in  1  block enable; 0 behaves as reset, except the holding register is kept.
- i_scl  in  1  SCL pin input.
- i_sda  in  1  SDA pin input.
- o_scl_oe  out  1  1 = pull SCL low (stretch).
- o_sda_oe  out  1  1 = pull SDA low; the pad drives 0 only, never 1.
- i_tx_data  in  8  next byte to send.
- i_tx_valid  in  1  i_tx_data is valid.
- o_tx_ready  out  1  holding register is empty.
- o_busy  out  1  addressed transaction in progress.
- o_addr_hit  out  1  1-cycle pulse on address+read match.
- o_byte_done  out  1  1-cycle pulse when the master's ACK/NACK has been sampled.
- o_nack  out  1  sticky flag: master NACKed the last byte; cleared at next START.
- o_underrun  out  1  sticky flag: a byte was needed while holding was empty; cleared at next START.

## Operation
- SCL/SDA pass through a 2-FF synchronizer, then a 1-FF edge stage.
  - scl_rise / scl_fall are derived from synchronized SCL.
  - START = SDA falling while SCL=1; STOP = SDA rising while SCL=1.
- Holding register: loads on i_tx_valid && o_tx_ready, which clears o_tx_ready. Moving the byte into the shift register sets o_tx_ready.
- States: IDLE, ADDR, ADDR_ACK, TX_BYTE, RX_ACK, WAIT_STOP.
  - IDLE: on START, clear o_nack/o_underrun, bit counter=7, go to ADDR.
  - ADDR: sample SDA on each scl_rise into an 8-bit shifter. After 8 bits:
    - if addr==ADDR and R/W==1, go to ADDR_ACK and pulse o_addr_hit;
    - otherwise go to WAIT_STOP with SDA released (no ACK).
  - ADDR_ACK: drive SDA low from the scl_fall after the 8th bit until the next scl_fall. At that fall, load the shift register, drive the MSB, go to TX_BYTE.
  - TX_BYTE: on each scl_fall, shift and drive the next bit (o_sda_oe = ~bit). After the 8th bit's scl_fall, release SDA and go to RX_ACK.
  - RX_ACK: on scl_rise, sample SDA and pulse o_byte_done.
    - SDA=0: next scl_fall loads the next byte and goes to TX_BYTE.
    - SDA=1: set o_nack, go to WAIT_STOP.
  - WAIT_STOP: SDA released; wait for START or STOP.
- START detected in any state (repeated start) → ADDR, SDA released.
- STOP detected in any state → IDLE, all oe released.
- o_busy = state ∈ {ADDR_ACK, TX_BYTE, RX_ACK}.
- Empty holding register at a load point: behaviour is set by Configuration.
- Reset or !i_en mid-transfer: oe outputs drop in the same cycle; state returns to IDLE and flags clear.

## Timing
- Reset values: o_scl_oe=0, o_sda_oe=0, o_tx_ready=1, o_busy=0, o_addr_hit=0, o_byte_done=0, o_nack=0, o_underrun=0.
- Pin-to-detect latency: 3 i_clk (sync + edge).
- SDA changes 1 i_clk after internal scl_fall, i.e. 4 i_clk after the pin edge. This gives ≥4 i_clk hold after SCL low.
- o_addr_hit is asserted the cycle after the scl_rise that samples R/W.
- o_byte_done is asserted the cycle after the ACK-bit scl_rise.
- A holding write in the same cycle as a load point is used for that load; no underrun results.

## Configuration
- I2C_SLAVE_TX_CLK_STRETCH_EN defined, empty holding at a load point:
  - assert o_scl_oe in the cycle after scl_fall, with SDA held at its previous state;
  - when i_tx_valid arrives, load the byte and drive the MSB that cycle;
  - release o_scl_oe 2 i_clk later;
  - no underrun is flagged.
- Macro undefined: o_scl_oe is tied 0. An empty load point sends 8'hFF and sets o_underrun.

## Structure
- Shared package i2c_pkg holds:
  - the state enum i2c_stx_state_t;
  - the constant I2C_RW_READ=1'b1;
  - the constant SYNC_STAGES=2.
- Sub-module i2c_bus_sync: synchronizers plus scl_rise/scl_fall/start/stop detection, reusable by the master blocks.

## Test plan
- Preload 8'hA5, master reads addr 7'h50 with 1 byte then NACK → ACK on address; SDA carries A5 MSB-first; o_addr_hit ×1, o_byte_done ×1, o_nack=1; STOP → IDLE.
- Master addresses 7'h51 → no ACK (SDA released); FSM stays in WAIT_STOP until STOP; o_addr_hit never pulses.
- Master writes (R/W=0) to 7'h50 → no ACK, o_busy stays 0.
- 3-byte read 11,22,33 fed just-in-time through valid/ready, master ACKs twice then NACKs → bytes 11 22 33 on the bus; o_tx_ready low→high once per byte.
- Empty holding at the first load point: with the macro, SCL is held low until valid=8'h3C, then 3C is sent; without the macro, FF is sent and o_underrun=1.
- Repeated START mid-byte, then i_rst_n low mid-byte → repeated START returns to ADDR and a new transfer completes; reset drops both oe in the same cycle and all outputs take their reset values.
